// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed display scanner with a double-buffered
// frame register. A prescaler paces the digit slots, Scan walks 0..3, and a new
// frame written through wr_* is held in a shadow set until the next frame
// boundary, so the visible digits never tear mid-frame.
//
// Optional feature macro: DISP_SCAN_BLINK_EN
//   defined   -> adds the blink input and a frame counter that toggles a blink
//                phase every BLINK_FRAMES frame boundaries; blinking digits are
//                forced blank during the high phase.
//   undefined -> no blink port, LES follows the active blank bits directly.
module disp_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_hexs,
    input  logic [3:0]  wr_point,
    input  logic [3:0]  wr_les,
`ifdef DISP_SCAN_BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic        wr_ready,
    output logic [1:0]  Scan,
    output logic [15:0] Hexs,
    output logic [3:0]  point,
    output logic [3:0]  LES,
    output logic        frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    // Elaboration-time guards on the parameter ranges.
    if (PRESCALE < 2 || PRESCALE > (1 << 20)) begin : g_bad_prescale
        $error("disp_scan_ctrl: PRESCALE out of range");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("disp_scan_ctrl: BLINK_FRAMES must be at least 1");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    scan_q, scan_d;
    logic          fd_q;
    logic          pend_q, pend_d;
    logic [15:0]   shd_hex_q, shd_hex_d;
    logic [3:0]    shd_pt_q, shd_pt_d;
    logic [3:0]    shd_les_q, shd_les_d;
    logic [15:0]   act_hex_q, act_hex_d;
    logic [3:0]    act_pt_q, act_pt_d;
    logic [3:0]    act_les_q, act_les_d;

    logic tick;
    logic boundary;
    logic accept;

    assign tick     = (presc_q == PS_LAST);
    assign boundary = tick && (scan_q == 2'd3);
    assign accept   = wr_en && !pend_q;
    assign wr_ready = !pend_q;

    // Next-state for the slot timer, digit select and the two frame buffers.
    // A write accepted in a boundary cycle lands in shadow only; the swap
    // uses the shadow contents as they were before that edge.
    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        scan_d    = tick ? scan_q + 2'd1 : scan_q;
        pend_d    = pend_q;
        shd_hex_d = shd_hex_q;
        shd_pt_d  = shd_pt_q;
        shd_les_d = shd_les_q;
        act_hex_d = act_hex_q;
        act_pt_d  = act_pt_q;
        act_les_d = act_les_q;
        if (boundary && pend_q) begin
            act_hex_d = shd_hex_q;
            act_pt_d  = shd_pt_q;
            act_les_d = shd_les_q;
            pend_d    = 1'b0;
        end
        if (accept) begin
            shd_hex_d = wr_hexs;
            shd_pt_d  = wr_point;
            shd_les_d = wr_les;
            pend_d    = 1'b1;
        end
    end

    // State registers; reset blanks every digit and drops any pending frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            scan_q    <= 2'd0;
            fd_q      <= 1'b0;
            pend_q    <= 1'b0;
            shd_hex_q <= 16'h0000;
            shd_pt_q  <= 4'h0;
            shd_les_q <= 4'h0;
            act_hex_q <= 16'h0000;
            act_pt_q  <= 4'h0;
            act_les_q <= 4'hF;
        end else begin
            presc_q   <= presc_d;
            scan_q    <= scan_d;
            fd_q      <= boundary;
            pend_q    <= pend_d;
            shd_hex_q <= shd_hex_d;
            shd_pt_q  <= shd_pt_d;
            shd_les_q <= shd_les_d;
            act_hex_q <= act_hex_d;
            act_pt_q  <= act_pt_d;
            act_les_q <= act_les_d;
        end
    end

`ifdef DISP_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;

    // Blink phase advances once per BLINK_FRAMES completed frames.
    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (boundary) begin
            if (frm_q == FR_LAST) begin
                frm_d   = '0;
                phase_d = !phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // Frame counter and blink phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign LES = act_les_q | (blink & {4{phase_q}});
`else
    assign LES = act_les_q;
`endif

    assign Scan       = scan_q;
    assign Hexs       = act_hex_q;
    assign point      = act_pt_q;
    assign frame_done = fd_q;

endmodule
